axis_segmented_bram_writer: RTL

- Write-side counterpart of the segmented BRAM reader.
- Accepts an AXI4-Stream on its slave port and writes consecutive beats into one BRAM segment, from a start offset up to an inclusive end address.
- Reports completion to the sequencing logic through a valid/ready event port, and exposes the live write pointer for software polling.
- Sits between acquisition/DMA stream sources and the shared sequence/waveform BRAMs.

---
 rtl/axis_segmented_bram_writer_if.sv | 43 ++++
 rtl/axis_segmented_bram_writer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/axis_segmented_bram_writer_if.sv
// axis_segmented_bram_writer_if
// Bundles the stream, completion-event and BRAM port A signals of the
// segmented BRAM writer.
//   s_axis_*        : AXI4-Stream data input (tready driven by the writer)
//   m_axis_done_*   : segment-complete event (tvalid driven by the writer)
//   bram_porta_*    : BRAM write port, all driven by the writer
// Modport slave is the writer's view; modport master is the surrounding
// logic (stream source, event sink, BRAM).
interface axis_segmented_bram_writer_if #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 10
);
  logic                         s_axis_tready;
  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata;
  logic                         s_axis_tvalid;
  logic                         s_axis_tlast;
  logic                         m_axis_done_tvalid;
  logic                         m_axis_done_tready;
  logic                         bram_porta_clk;
  logic                         bram_porta_rst;
  logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr;
  logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wrdata;
  logic [BRAM_DATA_WIDTH/8-1:0] bram_porta_we;

  modport slave (
    output s_axis_tready,
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output m_axis_done_tvalid,
    input  m_axis_done_tready,
    output bram_porta_clk, bram_porta_rst, bram_porta_addr,
    output bram_porta_wrdata, bram_porta_we
  );

  modport master (
    input  s_axis_tready,
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  m_axis_done_tvalid,
    output m_axis_done_tready,
    input  bram_porta_clk, bram_porta_rst, bram_porta_addr,
    input  bram_porta_wrdata, bram_porta_we
  );
endinterface

// File: rtl/axis_segmented_bram_writer.sv
// axis_segmented_bram_writer
// Writes consecutive AXI4-Stream beats into one BRAM segment, from a latched
// start offset up to a latched inclusive end address, then reports completion
// on a valid/ready event. In continuous mode the pointer wraps back to the
// offset and writing never pauses.
// Ports:
//   aclk, areset       : clock, asynchronous active-high reset
//   start              : one-cycle pulse arming a segment (honoured in IDLE only)
//   current_offset     : segment start address, latched on start
//   cfg_data           : segment end address (inclusive), latched on start
//   sts_data           : live write pointer (next address to be written)
//   sts_short          : segment ended by tlast before the end address
//   sts_overrun        : completion event raised while the previous one pending
//   bus                : stream / done event / BRAM port A (slave modport)
//
// state | meaning
// IDLE  | waiting for start, stream stalled
// WRITE | accepting beats, one BRAM write per beat
// DONE  | segment finished, holding done event until accepted
module axis_segmented_bram_writer #(
  parameter int    AXIS_TDATA_WIDTH = 32,
  parameter int    BRAM_DATA_WIDTH  = 32,
  parameter int    BRAM_ADDR_WIDTH  = 10,
  parameter string CONTINUOUS       = "FALSE"
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       start,
  input  logic [BRAM_ADDR_WIDTH-1:0] current_offset,
  input  logic [BRAM_ADDR_WIDTH-1:0] cfg_data,
  output logic [BRAM_ADDR_WIDTH-1:0] sts_data,
  output logic                       sts_short,
  output logic                       sts_overrun,
  axis_segmented_bram_writer_if.slave bus
);
  localparam int WE_WIDTH = BRAM_DATA_WIDTH / 8;
  localparam bit CONT     = (CONTINUOUS == "TRUE");

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                     state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0] offset_reg, end_reg;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q;
  logic [BRAM_DATA_WIDTH-1:0] wrdata_q, tdata_ext;
  logic [WE_WIDTH-1:0]        we_q;
  logic                       done_q;
  logic                       tready;
  logic                       beat, end_hit, seg_end, arm, empty_seg;

  generate
    if (AXIS_TDATA_WIDTH >= BRAM_DATA_WIDTH) begin : g_trunc
      assign tdata_ext = bus.s_axis_tdata[BRAM_DATA_WIDTH-1:0];
    end else begin : g_zext
      assign tdata_ext = {{(BRAM_DATA_WIDTH-AXIS_TDATA_WIDTH){1'b0}}, bus.s_axis_tdata};
    end
  endgenerate

  assign beat      = bus.s_axis_tvalid & tready;
  assign end_hit   = (sts_data == end_reg);
  assign seg_end   = beat & (end_hit | bus.s_axis_tlast);
  assign arm       = (state_q == IDLE) & start;
  assign empty_seg = current_offset > cfg_data;

  assign bus.s_axis_tready      = tready;
  assign bus.m_axis_done_tvalid = done_q;
  assign bus.bram_porta_clk     = aclk;
  assign bus.bram_porta_rst     = areset;
  assign bus.bram_porta_addr    = addr_q;
  assign bus.bram_porta_wrdata  = wrdata_q;
  assign bus.bram_porta_we      = we_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    tready  = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = empty_seg ? DONE : WRITE;
      WRITE: begin
        tready = 1'b1;
        if (seg_end && !CONT) state_d = DONE;
      end
      DONE:  if (bus.m_axis_done_tready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      offset_reg  <= '0;
      end_reg     <= '0;
      sts_data    <= '0;
      sts_short   <= 1'b0;
      sts_overrun <= 1'b0;
      addr_q      <= '0;
      wrdata_q    <= '0;
      we_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      we_q <= beat ? '1 : '0;
      if (beat) begin
        addr_q   <= sts_data;
        wrdata_q <= tdata_ext;
      end

      if (arm) begin
        offset_reg <= current_offset;
        end_reg    <= cfg_data;
        sts_data   <= current_offset;
        sts_short  <= empty_seg;
      end else if (seg_end) begin
        // ending without reaching end_reg can only mean tlast came early
        sts_short <= ~end_hit;
        sts_data  <= CONT ? offset_reg : sts_data + 1'b1;
      end else if (beat) begin
        sts_data <= sts_data + 1'b1;
      end

      // a fresh end beat wins over a same-cycle acceptance of the old event
      if (seg_end || (arm && empty_seg))    done_q <= 1'b1;
      else if (bus.m_axis_done_tready)      done_q <= 1'b0;

      if (CONT && seg_end && done_q && !bus.m_axis_done_tready)
        sts_overrun <= 1'b1;
    end
  end
endmodule
